// File: rtl/cosim_driver_pkg.sv
// Shared types and defaults for the co-simulation reset sequencer.
// State encoding, default timing constants and a width helper.
package cosim_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_HANDSHAKE = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  localparam int DEF_RESET_CYCLES   = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cosim_cycle_counter.sv
// Run-length counter: clear, enable and terminal compare.
// A zero limit never produces a terminal hit, so the count wraps.
module cosim_cycle_counter #(
  parameter int CYCLE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [CYCLE_W-1:0] limit,
  output logic [CYCLE_W-1:0] count,
  output logic               hit
);

  logic [CYCLE_W-1:0] count_q, count_d;
  logic [CYCLE_W-1:0] count_inc;

  assign count_inc = count_q + CYCLE_W'(1);

  // Next count: clear wins over enable.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_inc;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Terminal: this increment lands on a nonzero limit.
  always_comb begin
    hit = (limit != '0) && (count_inc == limit);
  end

  assign count = count_q;

endmodule

// File: rtl/cosim_reset_sequencer.sv
// Staggered reset release and bounded run for cosim domains.
// Optional handshake watchdog: ESI_COSIM_RESET_TIMEOUT_EN.
module cosim_reset_sequencer
  import cosim_driver_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int CYCLE_W        = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CYCLE_W-1:0]      cycle_limit,
  input  logic [NUM_CHANNELS-1:0] chan_ready,
  output logic [NUM_CHANNELS-1:0] chan_rst,
  output logic                    running,
  output logic                    done,
  output logic                    timeout,
  output logic [CYCLE_W-1:0]      cycle_count,
  output logic [2:0]              state
);

  localparam int RW = cnt_w(RESET_CYCLES);
  localparam int IW = cnt_w(NUM_CHANNELS);
  localparam logic [RW-1:0] R_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_CHANNELS - 1);

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16 ||
      RESET_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
      CYCLE_W < 1) begin : g_param_err
    $error("cosim_reset_sequencer: bad parameter");
  end

  state_e                  state_q, state_d;
  logic [CYCLE_W-1:0]      limit_q, limit_d;
  logic [RW-1:0]           rcnt_q, rcnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NUM_CHANNELS-1:0] chan_rst_q, chan_rst_d;
  logic                    running_q, done_q;
  logic                    cnt_clr, cnt_en, cnt_hit;
  logic                    rdy_cur;
  logic                    to_hit;

  // Only the most recently released channel is listened to.
  assign rdy_cur = chan_ready[idx_q];
  assign cnt_en  = (state_q == ST_RUN);

  // Sequencer next state.
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    rcnt_d  = rcnt_q;
    idx_d   = idx_q;
    cnt_clr = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start) begin
          state_d = ST_RESET;
          limit_d = cycle_limit;
          rcnt_d  = '0;
          idx_d   = '0;
          cnt_clr = 1'b1;
        end
      end
      ST_RESET: begin
        if (rcnt_q == R_LAST) begin
          state_d = ST_HANDSHAKE;
          idx_d   = '0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      ST_HANDSHAKE: begin
        if (rdy_cur) begin
          if (idx_q == I_LAST) begin
            state_d = ST_RUN;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (to_hit) begin
          state_d = ST_FAULT;
          cnt_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_hit) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Channel resets: channels 0..idx released while handshaking.
  always_comb begin
    chan_rst_d = '1;
    if (state_d == ST_RUN) begin
      chan_rst_d = '0;
    end else if (state_d == ST_HANDSHAKE) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        chan_rst_d[i] = (i > int'(idx_d));
      end
    end
  end

  // Sequencer registers; rst overrides any start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      limit_q    <= '0;
      rcnt_q     <= '0;
      idx_q      <= '0;
      chan_rst_q <= '1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      rcnt_q     <= rcnt_d;
      idx_q      <= idx_d;
      chan_rst_q <= chan_rst_d;
      running_q  <= (state_d == ST_RUN);
      done_q     <= (state_d == ST_DONE);
    end
  end

  cosim_cycle_counter #(
    .CYCLE_W (CYCLE_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (limit_q),
    .count (cycle_count),
    .hit   (cnt_hit)
  );

`ifdef ESI_COSIM_RESET_TIMEOUT_EN
  localparam int WW = cnt_w(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          timeout_q;

  assign to_hit = (wcnt_q == W_LAST);

  // Wait count restarts whenever a channel is released.
  always_comb begin
    wcnt_d = wcnt_q;
    if (state_q != ST_HANDSHAKE || rdy_cur) begin
      wcnt_d = '0;
    end else if (!to_hit) begin
      wcnt_d = wcnt_q + WW'(1);
    end
  end

  // Watchdog and fault flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      timeout_q <= (state_d == ST_FAULT);
    end
  end

  assign timeout = timeout_q;
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign chan_rst = chan_rst_q;
  assign running  = running_q;
  assign done     = done_q;
  assign state    = state_q;

endmodule
